// File: rtl/spi_ram_pkg.sv
// rtl/spi_ram_pkg.sv - shared opcodes, widths and master FSM states for the SPI RAM link
package spi_ram_pkg;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  localparam int FRAME_W = 11;
  localparam int DATA_W  = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEL   = 3'd1,
    SHIFT = 3'd2,
    TURN  = 3'd3,
    READ  = 3'd4,
    GAPST = 3'd5
  } state_t;

  // Bit 10 duplicates op[1] so the slave sees its read/write select first.
  function automatic logic [FRAME_W-1:0] make_frame(input logic [1:0] op,
                                                    input logic [DATA_W-1:0] data);
    return {op[1], op, data};
  endfunction

endpackage

// File: rtl/spi_ram_master.sv
// rtl/spi_ram_master.sv - command-level SPI master driving the SPI RAM slave
// Pins are registered from the state, so SS_n/MOSI trail the FSM by one clk.
module spi_ram_master
  import spi_ram_pkg::*;
#(
  parameter int RD_TURN = 2,
  parameter int GAP     = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [DATA_W-1:0] req_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              SS_n,
  output logic              MOSI,
  input  logic              MISO
);

  state_t               state;
  logic [3:0]           cnt;
  logic [FRAME_W-1:0]   frame;
  logic [DATA_W-1:0]    rx;
  logic                 is_rd;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      frame     <= '0;
      rx        <= '0;
      is_rd     <= 1'b0;
      SS_n      <= 1'b1;
      MOSI      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          SS_n <= 1'b1;
          MOSI <= 1'b0;
          if (req_valid) begin
            frame <= make_frame(req_op, req_data);
            is_rd <= (req_op == OP_RD_DATA);
            cnt   <= '0;
            state <= SEL;
          end
        end
        SEL: begin
          SS_n  <= 1'b0;
          MOSI  <= 1'b0;
          cnt   <= '0;
          state <= SHIFT;
        end
        SHIFT: begin
          SS_n  <= 1'b0;
          MOSI  <= frame[FRAME_W-1];
          frame <= {frame[FRAME_W-2:0], 1'b0};
          if (cnt == 4'(FRAME_W - 1)) begin
            cnt   <= '0;
            state <= is_rd ? TURN : GAPST;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        TURN: begin
          SS_n <= 1'b0;
          MOSI <= 1'b0;
          if (cnt == 4'(RD_TURN - 1)) begin
            cnt   <= '0;
            state <= READ;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        READ: begin
          SS_n <= 1'b0;
          MOSI <= 1'b0;
          rx   <= {rx[DATA_W-2:0], MISO};
          // The 8th sample goes straight into rsp_data so the pulse lines up with it.
          if (cnt == 4'(DATA_W - 1)) begin
            rsp_data  <= {rx[DATA_W-2:0], MISO};
            rsp_valid <= 1'b1;
            cnt       <= '0;
            state     <= GAPST;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        GAPST: begin
          SS_n <= 1'b1;
          MOSI <= 1'b0;
          if (cnt == 4'(GAP - 1)) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: begin
          SS_n  <= 1'b1;
          MOSI  <= 1'b0;
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
